// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among completing functional units,
// registered single-cycle broadcast of the winning result, and a saturating broadcast counter.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               clock,
    input logic               reset,
    input logic               flush,
    input logic [NUM_REQ-1:0] req_valid,
    input logic [NUM_REQ-1:0] req_ready
);

    a_ready_onehot0: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(req_ready));

    a_flush_blocks_grant: assert property (@(posedge clock) disable iff (!reset)
        flush |-> (req_ready == {NUM_REQ{1'b0}}));

    a_ready_only_if_valid: assert property (@(posedge clock) disable iff (!reset)
        ((req_ready & ~req_valid) == {NUM_REQ{1'b0}}));

    a_work_conserving: assert property (@(posedge clock) disable iff (!reset)
        (!flush && (req_valid != {NUM_REQ{1'b0}})) |-> (req_ready != {NUM_REQ{1'b0}}));

endmodule

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = `ROB_TAG_LEN,
    parameter int DATA_W  = `XLEN,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [IDX_W-1:0]          cdb_src,
    output logic [31:0]               cdb_count
);

    // Requester index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_REQ)) begin
            sum = sum - 32'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    logic [TAG_W-1:0]  tag_s   [NUM_REQ];
    logic [DATA_W-1:0] value_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign tag_s[g]   = req_tag[g*TAG_W +: TAG_W];
        assign value_s[g] = req_value[g*DATA_W +: DATA_W];
    end

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [IDX_W-1:0]  cdb_src_q, cdb_src_d;
    logic [31:0]       cdb_count_q, cdb_count_d;

    logic              gnt_found_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic [IDX_W-1:0]  cand_s;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = idx_wrap(rr_ptr_q, 32'(k));
            if (!gnt_found_s && req_valid[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
                gnt_idx_s   = gnt_idx_s;
            end
        end
    end

    // Grant is suppressed during reset and on a flush cycle.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (reset && !flush && gnt_found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next broadcast and pointer; tag 0 consumes the grant but broadcasts nothing.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            rr_ptr_d    = {IDX_W{1'b0}};
            cdb_valid_d = 1'b0;
        end else if (gnt_found_s) begin
            rr_ptr_d    = idx_wrap(gnt_idx_s, 32'd1);
            cdb_valid_d = (tag_s[gnt_idx_s] != {TAG_W{1'b0}});
            cdb_tag_d   = tag_s[gnt_idx_s];
            cdb_value_d = value_s[gnt_idx_s];
            cdb_src_d   = gnt_idx_s;
        end else begin
            rr_ptr_d    = rr_ptr_q;
            cdb_valid_d = 1'b0;
        end
    end

    // Saturating count of real broadcasts; untouched by flush.
    always_comb begin
        if (cdb_valid_d && (cdb_count_q != 32'hFFFF_FFFF)) begin
            cdb_count_d = cdb_count_q + 32'd1;
        end else begin
            cdb_count_d = cdb_count_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= {IDX_W{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= {TAG_W{1'b0}};
            cdb_value_q <= {DATA_W{1'b0}};
            cdb_src_q   <= {IDX_W{1'b0}};
            cdb_count_q <= 32'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
            cdb_count_q <= cdb_count_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;
    assign cdb_count = cdb_count_q;

    cdb_arbiter_chk #(
        .NUM_REQ(NUM_REQ)
    ) u_chk (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready)
    );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected broadcasts,
// a negedge monitor pops and compares whenever the DUT drives cdb_valid.

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_value;
    logic [N-1:0]      req_ready;
    logic              flush;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_value;
    logic [1:0]        cdb_src;
    logic [31:0]       cdb_count;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_tag  (req_tag),
        .req_value(req_value),
        .req_ready(req_ready),
        .flush    (flush),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_value(cdb_value),
        .cdb_src  (cdb_src),
        .cdb_count(cdb_count)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        logic [1:0]    src;
        logic [31:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    bit          pending_idle = 1'b0;
    logic [31:0] idle_cnt = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
        req_tag[i*TW +: TW]   = t;
        req_value[i*DW +: DW] = v;
    endtask

    // One arbitration cycle: drive, check grant, queue the expected broadcast.
    task automatic step(input string name, input logic [3:0] v, input logic fl,
                        input logic [3:0] rdy, input logic bc, input logic [TW-1:0] t,
                        input logic [DW-1:0] val, input logic [1:0] src, input logic [31:0] cnt);
        @(posedge clock);
        #1;
        if (pending_idle) begin
            check({name, "_prev_idle_valid"}, 64'(cdb_valid), 64'd0);
            check({name, "_prev_idle_count"}, 64'(cdb_count), 64'(idle_cnt));
        end
        req_valid = v;
        flush     = fl;
        #2;
        check({name, "_ready"}, 64'(req_ready), 64'(rdy));
        if (bc) exp_q.push_back('{t, val, src, cnt});
        pending_idle = !bc;
        idle_cnt     = cnt;
    endtask

    // Monitor: every broadcast must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset === 1'b1 && cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_broadcast actual tag=%0h src=%0d required none", cdb_tag, cdb_src);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcast_tag",   64'(cdb_tag),   64'(mon_e.tag));
                check("bcast_value", 64'(cdb_value), 64'(mon_e.val));
                check("bcast_src",   64'(cdb_src),   64'(mon_e.src));
                check("bcast_count", 64'(cdb_count), 64'(mon_e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_tag   = '0;
        req_value = '0;
        #12;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_tag",   64'(cdb_tag),   64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_src",   64'(cdb_src),   64'd0);
        check("rst_count", 64'(cdb_count), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        req_valid = 4'b0000;
        set_req(0, 6'd10, 32'd100);
        set_req(1, 6'd11, 32'd101);
        set_req(2, 6'd5,  32'hDEAD_BEEF);
        set_req(3, 6'd13, 32'd103);
        @(posedge clock);
        #1;
        reset = 1'b1;

        step("single",  4'b0100, 1'b0, 4'b0100, 1'b1, 6'd5, 32'hDEAD_BEEF, 2'd2, 32'd1);
        step("idle",    4'b0000, 1'b0, 4'b0000, 1'b0, 6'd0, 32'd0, 2'd0, 32'd1);
        set_req(2, 6'd12, 32'd102);
        // rr_ptr is 3 here: search wraps to requester 0, then 1.
        step("wrap0",   4'b0011, 1'b0, 4'b0001, 1'b1, 6'd10, 32'd100, 2'd0, 32'd2);
        step("wrap1",   4'b0010, 1'b0, 4'b0010, 1'b1, 6'd11, 32'd101, 2'd1, 32'd3);
        step("flush",   4'b1111, 1'b1, 4'b0000, 1'b0, 6'd0, 32'd0, 2'd0, 32'd3);
        step("postfl",  4'b1111, 1'b0, 4'b0001, 1'b1, 6'd10, 32'd100, 2'd0, 32'd4);
        step("tzgap",   4'b0000, 1'b0, 4'b0000, 1'b0, 6'd0, 32'd0, 2'd0, 32'd4);
        set_req(1, 6'd0, 32'd55);
        step("tagzero", 4'b0010, 1'b0, 4'b0010, 1'b0, 6'd0, 32'd0, 2'd0, 32'd4);
        step("tzgap2",  4'b0000, 1'b0, 4'b0000, 1'b0, 6'd0, 32'd0, 2'd0, 32'd4);
        set_req(1, 6'd11, 32'd101);
        // rr_ptr must now be 2: requester 2 wins over 0 and 1.
        step("after_tz", 4'b0111, 1'b0, 4'b0100, 1'b1, 6'd12, 32'd102, 2'd2, 32'd5);

        // Asynchronous reset between edges while a broadcast is live and req 3 is granted.
        @(posedge clock);
        #1;
        req_valid = 4'b1000;
        #2;
        check("abort_ready", 64'(req_ready), 64'b1000);
        @(negedge clock);
        #2;
        check("pre_reset_valid", 64'(cdb_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async_valid", 64'(cdb_valid), 64'd0);
        check("async_count", 64'(cdb_count), 64'd0);
        check("async_tag",   64'(cdb_tag),   64'd0);
        check("async_src",   64'(cdb_src),   64'd0);
        check("async_ready", 64'(req_ready), 64'd0);
        req_valid    = 4'b0000;
        pending_idle = 1'b0;
        @(posedge clock);
        #1;
        check("abort_no_bcast", 64'(cdb_valid), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step("rr", 4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b1, TW'(10 + (i % 4)),
                 DW'(100 + (i % 4)), 2'(i % 4), 32'(i + 1));
        end
        step("drain", 4'b0000, 1'b0, 4'b0000, 1'b0, 6'd0, 32'd0, 2'd0, 32'd8);
        @(posedge clock);
        #1;
        check("final_valid", 64'(cdb_valid), 64'd0);
        check("final_count", 64'(cdb_count), 64'd8);
        @(negedge clock);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
